// File: rtl/disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_pkg : shared state encoding, digit selects and segment table for the
//            two-digit scan controller.              Rev 1.0
// ---------------------------------------------------------------------------
package disp_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    DIG0 = 3'd1,
    GAP0 = 3'd2,
    DIG1 = 3'd3,
    GAP1 = 3'd4
  } scan_state_t;

  localparam logic [1:0] DSEL_NONE = 2'b00;
  localparam logic [1:0] DSEL_0    = 2'b01;
  localparam logic [1:0] DSEL_1    = 2'b10;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment order {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_ctrl_seg7_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_dec : combinational hex nibble to seven-segment decoder.   Rev 1.0
// ---------------------------------------------------------------------------
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_scan_ctrl : two-digit multiplexed display scanner with blanking gaps
//                  and a frame-synchronous shadow/active value register. Rev 1.0
// ---------------------------------------------------------------------------
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIV     = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] value,
  input  logic       load,
  output logic [1:0] d,
  output logic [6:0] seg,
  output logic       s_clk,
  output logic       pending,
  output logic       frame
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  scan_state_t state;
  scan_state_t nxt_state;

  logic [15:0] pre_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  shadow;
  logic [7:0]  active;

  logic        xfer;
  logic        frame_set;
  logic        in_dig;
  logic        in_gap;

  logic [3:0]  nib;
  logic        dig_on;
  logic [6:0]  dec_seg;

  always_comb begin
    nxt_state = state;
    case (state)
      OFF:     nxt_state = DIG0;
      DIG0:    if (pre_cnt == DIV_LAST) nxt_state = GAP0;
      GAP0:    if (gap_cnt == GAP_LAST) nxt_state = DIG1;
      DIG1:    if (pre_cnt == DIV_LAST) nxt_state = GAP1;
      GAP1:    if (gap_cnt == GAP_LAST) nxt_state = DIG0;
      default: nxt_state = OFF;
    endcase
    if (!en) nxt_state = OFF;
  end

  always_comb begin
    in_dig = (state == DIG0) || (state == DIG1);
    in_gap = (state == GAP0) || (state == GAP1);
    // Active only moves at a frame boundary or while dark, so a frame never tears.
    xfer = ((nxt_state == DIG0) && ((state == OFF) || (state == GAP1))) ||
           ((state == OFF) && pending);
    frame_set = (state == GAP1) && (nxt_state == DIG0) && pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      pre_cnt <= '0;
      gap_cnt <= '0;
      frame   <= 1'b0;
    end else begin
      state   <= nxt_state;
      pre_cnt <= (in_dig && (nxt_state == state)) ? pre_cnt + 16'd1 : 16'd0;
      gap_cnt <= (in_gap && (nxt_state == state)) ? gap_cnt + 8'd1 : 8'd0;
      frame   <= frame_set;
    end
  end

  // On a load/transfer collision active takes the old shadow and pending stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (xfer) active <= shadow;
      if (load) shadow <= value;
      if (load) begin
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    d      = DSEL_NONE;
    s_clk  = 1'b0;
    nib    = active[3:0];
    dig_on = 1'b0;
    case (state)
      DIG0: begin
        d      = DSEL_0;
        dig_on = 1'b1;
      end
      DIG1: begin
        d      = DSEL_1;
        s_clk  = 1'b1;
        nib    = active[7:4];
        dig_on = 1'b1;
      end
      GAP1:    s_clk = 1'b1;
      default: ;
    endcase
  end

  seg7_dec u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  assign seg = dig_on ? dec_seg : SEG_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_disp_scan_ctrl : directed + random bench with a frame-position model.
// ---------------------------------------------------------------------------
module tb_disp_scan_ctrl;

  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int FL  = 2 * (DIV + GAP);

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] value;
  logic       load;
  logic [1:0] d;
  logic [6:0] seg;
  logic       s_clk;
  logic       pending;
  logic       frame;

  int errors = 0;
  int checks = 0;

  bit         m_on;
  int         m_pos;
  logic [7:0] m_shadow;
  logic [7:0] m_active;
  bit         m_pending;
  bit         m_frame;
  logic [6:0] seg_ref [16];

  int n77, ngap, n4f;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIV(DIV), .GAP_CYC(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .value   (value),
    .load    (load),
    .d       (d),
    .seg     (seg),
    .s_clk   (s_clk),
    .pending (pending),
    .frame   (frame)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_shadow = 8'h00; m_active = 8'h00;
    m_pending = 0; m_frame = 0;
  endtask

  // One rising edge of the reference: frame position plus shadow/active rules.
  task automatic model_edge();
    bit last, xfer;
    if (rst) begin
      model_reset();
    end else begin
      last = m_on && (m_pos == FL - 1);
      xfer = (en && (!m_on || last)) || (!m_on && m_pending);
      m_frame = en && last && m_pending;
      if (xfer) m_active = m_shadow;
      if (load) m_pending = 1;
      else if (xfer) m_pending = 0;
      if (load) m_shadow = value;
      if (!en) m_on = 0;
      else if (!m_on) begin m_on = 1; m_pos = 0; end
      else m_pos = (m_pos + 1) % FL;
    end
  endtask

  function automatic logic [1:0] exp_d();
    if (!m_on) return 2'b00;
    if (m_pos < DIV) return 2'b01;
    if (m_pos < DIV + GAP) return 2'b00;
    if (m_pos < 2 * DIV + GAP) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [1:0] dd;
    dd = exp_d();
    if (dd == 2'b01) return seg_ref[m_active[3:0]];
    if (dd == 2'b10) return seg_ref[m_active[7:4]];
    return 7'h00;
  endfunction

  task automatic check_all();
    chk("d", {6'd0, d}, {6'd0, exp_d()});
    chk("seg", {1'b0, seg}, {1'b0, exp_seg()});
    chk("s_clk", {7'd0, s_clk}, {7'd0, (m_on && m_pos >= DIV + GAP)});
    chk("pending", {7'd0, pending}, {7'd0, m_pending});
    chk("frame", {7'd0, frame}, {7'd0, m_frame});
    checks++;
    assert (d !== 2'b11) else begin
      errors++;
      $error("FAIL d_onehot: observed=%0b expected=not 11", d);
    end
    checks++;
    assert (!(d === 2'b00 && seg !== 7'h00)) else begin
      errors++;
      $error("FAIL blank_seg: observed=%0h expected=0", seg);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (!(m_on && m_pos == target) && n < 3 * FL) begin
      step();
      n++;
    end
    checks++;
    assert (m_on && m_pos == target) else begin
      errors++;
      $error("FAIL wait_pos: observed=%0d expected=%0d", m_pos, target);
    end
  endtask

  initial begin
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 8'h00;

    repeat (3) step();
    chk("reset_d", {6'd0, d}, 8'h00);
    chk("reset_seg", {1'b0, seg}, 8'h00);
    #2 rst = 1'b0;
    step();

    // Basic scan of 3A, loaded while dark
    value = 8'h3A; load = 1'b1;
    step();
    load = 1'b0;
    chk("off_load_pending", {7'd0, pending}, 8'h01);
    step();
    chk("off_xfer_clears", {7'd0, pending}, 8'h00);
    en = 1'b1;
    step();
    chk("first_dig0_seg", {1'b0, seg}, 8'h77);
    n77 = 0; ngap = 0; n4f = 0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) step();
      if (d === 2'b01 && seg === 7'h77 && s_clk === 1'b0) n77++;
      else if (d === 2'b00 && seg === 7'h00) ngap++;
      else if (d === 2'b10 && seg === 7'h4F && s_clk === 1'b1) n4f++;
    end
    chk("dig0_cycles", 8'(n77), 8'd4);
    chk("gap_cycles", 8'(ngap), 8'd4);
    chk("dig1_cycles", 8'(n4f), 8'd4);
    step();
    chk("period_wrap", {1'b0, seg}, 8'h77);

    // Mid-frame load waits for the boundary
    wait_pos(DIV + GAP + 1);
    value = 8'h12; load = 1'b1;
    step();
    load = 1'b0;
    chk("midload_pending", {7'd0, pending}, 8'h01);
    chk("midload_unchanged", {1'b0, seg}, 8'h4F);
    wait_pos(0);
    chk("midload_frame", {7'd0, frame}, 8'h01);
    chk("midload_seg", {1'b0, seg}, 8'h5B);

    // Load colliding with the transfer edge
    wait_pos(DIV + GAP + 1);
    value = 8'h12; load = 1'b1;
    step();
    load = 1'b0;
    wait_pos(FL - 1);
    value = 8'h45; load = 1'b1;
    step();
    load = 1'b0;
    chk("coll_seg", {1'b0, seg}, 8'h5B);
    chk("coll_pending", {7'd0, pending}, 8'h01);
    chk("coll_frame", {7'd0, frame}, 8'h01);
    wait_pos(DIV + GAP);
    chk("coll_dig1", {1'b0, seg}, 8'h06);
    wait_pos(0);
    chk("next_frame_seg", {1'b0, seg}, 8'h6D);
    chk("next_frame_pending", {7'd0, pending}, 8'h00);

    // Enable drop in DIG0
    wait_pos(1);
    en = 1'b0;
    step();
    chk("drop_off", {6'd0, d}, 8'h00);
    en = 1'b1;
    step();
    chk("reen_dig0", {6'd0, d}, 8'h01);
    repeat (DIV - 1) step();
    chk("reen_dig0_last", {6'd0, d}, 8'h01);
    step();
    chk("reen_gap0", {6'd0, d}, 8'h00);

    // Asynchronous reset in the middle of DIG1
    value = 8'hA7; load = 1'b1;
    step();
    load = 1'b0;
    wait_pos(DIV + GAP + 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_d", {6'd0, d}, 8'h00);
    chk("async_seg", {1'b0, seg}, 8'h00);
    chk("async_pending", {7'd0, pending}, 8'h00);
    check_all();
    step();
    #2 rst = 1'b0;
    step();
    chk("resume_dig0", {6'd0, d}, 8'h01);

    // Random EN/LOAD/VALUE traffic
    for (int i = 0; i < 10000; i++) begin
      en    = ($urandom_range(0, 19) != 0);
      load  = ($urandom_range(0, 7) == 0);
      value = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
